pe_arbiter: RTL and testbench
=============================

# pe_arbiter

Sequential 4-requester arbiter built around the 4-to-2 priority-encoding function of the priority encoder block. It turns the encoder's combinational "highest active input wins" rule into a registered, held grant with release handshake, hold-time limit and an optional round-robin mode. It sits between four requesting agents and one shared resource, which it hands to exactly one agent at a time.

## Interface

Parameters:
- MAX_HOLD, default 16: maximum cycles a single grant may stay asserted. Legal range 1..255; hold counter width is 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk
- mode_rr  input  1  0 = fixed priority (req[3] highest, req[0] lowest); 1 = round-robin
- req  input  4  request vector, one bit per agent; level, held until served
- done  input  1  one-cycle release pulse from the currently granted agent
- gnt  output  4  one-hot grant, registered; all zero when idle
- gnt_id  output  2  encoded index of the granted agent, registered; 0 when idle
- gnt_vld  output  1  registered; high whenever gnt is non-zero
- timeout  output  1  registered one-cycle pulse: grant was revoked by MAX_HOLD

## Operation

- States: IDLE, BUSY.
- IDLE, req == 0: outputs stay 0.
- IDLE, req != 0: select winner, load gnt/gnt_id/gnt_vld, clear hold_cnt, go BUSY, record last_id = winner.
- Fixed mode winner: same as the priority encoder: req[3] > req[2] > req[1] > req[0].
- Round-robin winner: first set bit searching last_id+1, last_id+2, ... modulo 4 (wrap 3 -> 0). last_id resets to 3, so the first RR search order is 0,1,2,3.
- mode_rr is sampled only in IDLE; changes during BUSY have no effect on the current grant. last_id is updated in both modes.
- BUSY release conditions (any one, sampled each edge): done == 1; req[gnt_id] == 0; hold_cnt == MAX_HOLD-1.
- On release: gnt, gnt_id, gnt_vld -> 0; go IDLE. If release was by hold limit only (done == 0 and req[gnt_id] == 1), timeout = 1 for one cycle.
- done while IDLE is ignored. done and hold limit in the same cycle: normal release, timeout stays 0.
- A revoked (timed-out) agent is not masked; in fixed mode it may win again in the next IDLE cycle.
- hold_cnt increments by 1 each BUSY cycle without release; never wraps, because release occurs at MAX_HOLD-1.

## Timing

- Reset: state IDLE, gnt = 0, gnt_id = 0, gnt_vld = 0, timeout = 0, hold_cnt = 0, last_id = 3. Assertion takes effect immediately, including mid-grant.
- Grant latency: req sampled non-zero at edge k in IDLE -> gnt_vld high after edge k, i.e. one cycle.
- Release latency: release condition sampled at edge m -> gnt_vld low after edge m. timeout, when set, is high in the same cycle gnt_vld first reads 0.
- Minimum of one IDLE cycle between grants; the earliest next grant is edge m+1. Grant gap equals 1 cycle under continuous requests.
- Maximum grant length: gnt_vld high for exactly MAX_HOLD cycles when never released early.
- gnt is always one-hot or zero; gnt_vld == |gnt; gnt_id matches gnt.

## Test plan

- Fixed mode, req = 4'b1010 held, done after 3 BUSY cycles -> gnt = 4'b1000, gnt_id = 3 one cycle after req; released; after 1 idle cycle gnt = 4'b1000 again.
- RR mode after reset, req = 4'b1111 held, done pulse each grant -> gnt_id sequence 0,1,2,3,0, with one idle cycle between grants.
- MAX_HOLD = 4, req = 4'b0100 held, no done -> gnt_vld high exactly 4 cycles, then timeout = 1 for 1 cycle with gnt = 0; regrant to agent 2 on the next cycle.
- Granted agent drops req[1] while BUSY with no done -> gnt low on the next cycle, timeout = 0; done pulse in IDLE causes no change.
- rst_n low during BUSY with gnt = 4'b0010 -> all outputs 0 immediately. After release of reset in RR mode with req = 4'b0011, the first grant goes to agent 0.
- Toggle mode_rr during BUSY -> current grant unaffected; the new mode applies at the next IDLE arbitration. Check one-hot gnt and gnt_vld == |gnt every cycle.

Source files
------------

// File: rtl/pe_arbiter.sv
// Four-way arbiter with a registered, held grant. It supports fixed priority or round-robin, a done/req-drop release, and a hold limit.
// Latency: grant 1 cycle after a request in IDLE, release 1 cycle after its cause. There is always at least one idle cycle between grants.
module pe_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_rr,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [7:0] hold_cnt;
   logic [1:0] last_id;
   logic [1:0] fix_win;
   logic [1:0] rr_win;
   logic [1:0] win;
   logic       hold_hit;
   logic       release_now;

   always_comb begin
      fix_win = 2'd0;
      if (req[3])      fix_win = 2'd3;
      else if (req[2]) fix_win = 2'd2;
      else if (req[1]) fix_win = 2'd1;
   end

   // Walk offsets from farthest to nearest, so the nearest requester after last_id wins.
   always_comb begin
      rr_win = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         if (req[2'(last_id + 2'(i))]) rr_win = 2'(last_id + 2'(i));
      end
   end

   assign win         = mode_rr ? rr_win : fix_win;
   assign hold_hit    = (hold_cnt == HOLD_LAST);
   assign release_now = done || !req[gnt_id] || hold_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         gnt_id   <= 2'd0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= 8'd0;
         last_id  <= 2'd3;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt      <= 4'b0001 << win;
                  gnt_id   <= win;
                  gnt_vld  <= 1'b1;
                  hold_cnt <= 8'd0;
                  last_id  <= win;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (release_now) begin
                  gnt     <= 4'b0000;
                  gnt_id  <= 2'd0;
                  gnt_vld <= 1'b0;
                  // Only a pure hold-limit revoke is reported as a timeout.
                  timeout <= !done && req[gnt_id];
                  state   <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_arbiter.sv
// Directed bench for pe_arbiter (MAX_HOLD = 4): fixed, round-robin, hold-limit, req-drop, reset, mode toggle.
module tb_pe_arbiter;

   logic       clk;
   logic       rst_n;
   logic       mode_rr;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       timeout;

   int total = 0;
   int bad   = 0;
   logic inv_en = 1'b0;

   pe_arbiter #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode_rr (mode_rr),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                          input logic e_vld, input logic e_to);
      chk({tag, ".gnt"},     {4'b0, gnt},     {4'b0, e_gnt});
      chk({tag, ".gnt_id"},  {6'b0, gnt_id},  {6'b0, e_id});
      chk({tag, ".gnt_vld"}, {7'b0, gnt_vld}, {7'b0, e_vld});
      chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, e_to});
   endtask

   // Structural invariants, checked on every falling edge once out of reset.
   always @(negedge clk) begin
      if (inv_en) begin
         total++;
         assert ((gnt_vld === |gnt) && (gnt === (gnt_vld ? (4'b0001 << gnt_id) : 4'b0000))) else begin
            bad++;
            $error("FAIL invariant gnt=%b gnt_id=%0d gnt_vld=%b", gnt, gnt_id, gnt_vld);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   logic [1:0] rr_seq [5];

   initial begin
      rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst_n = 1'b0; mode_rr = 1'b0; req = 4'b0000; done = 1'b0;
      cyc(); cyc();
      chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      inv_en = 1'b1;
      cyc();
      chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Fixed priority: 1010 -> agent 3, done on the third busy cycle.
      req = 4'b1010;
      cyc();
      chk_out("fix_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
      cyc(); cyc();
      chk_out("fix_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      chk_out("fix_release", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      cyc();
      chk_out("fix_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      cyc();
      chk_out("fix_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Round-robin from reset: order 0,1,2,3,0.
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      mode_rr = 1'b1; req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk_out($sformatf("rr_grant%0d", k), 4'b0001 << rr_seq[k], rr_seq[k], 1'b1, 1'b0);
         done = 1'b1;
         cyc();
         chk_out($sformatf("rr_gap%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
         done = 1'b0;
      end
      req = 4'b0000;
      cyc();

      // Hold limit: agent 2 held 4 cycles, timeout, immediate regrant.
      mode_rr = 1'b0; req = 4'b0100;
      cyc();
      chk_out("hold_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("hold_vld%0d", k), {7'b0, gnt_vld}, 8'd1);
      end
      cyc();
      chk_out("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
      cyc();
      chk_out("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc(); cyc(); cyc();
      // done coincides with the hold limit: plain release.
      done = 1'b1;
      cyc();
      chk_out("hold_done_same", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;

      // Granted agent 1 drops its request; done while idle is ignored.
      req = 4'b0010;
      cyc();
      chk_out("drop_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
      cyc();
      req = 4'b0000;
      cyc();
      chk_out("drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b1;
      cyc();
      chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;

      // Asynchronous reset mid-grant, then RR restarts from agent 0.
      req = 4'b0010;
      cyc();
      chk_out("rst_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
      mode_rr = 1'b1; req = 4'b0011;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_out("rst_rr_first", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      done = 1'b0;
      cyc();
      chk_out("rst_rr_next", 4'b0010, 2'd1, 1'b1, 1'b0);

      // mode_rr toggled while busy only affects the next arbitration.
      mode_rr = 1'b0;
      cyc();
      chk_out("mode_busy_fix", 4'b0010, 2'd1, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      done = 1'b0;
      cyc();
      chk_out("mode_fix_win", 4'b0010, 2'd1, 1'b1, 1'b0);
      mode_rr = 1'b1;
      cyc();
      chk_out("mode_busy_rr", 4'b0010, 2'd1, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      done = 1'b0;
      cyc();
      chk_out("mode_rr_win", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      cyc();
      chk_out("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      inv_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
